// File: rtl/rx_ds_decode_pkg.sv
// Shared definitions for the DS receive decoder: L-char codes, marker bytes,
// FIFO entry layout and escape FSM state encodings.
package rx_DS_pkg;

  // L-char control codes carried in q[1:0]
  localparam logic [1:0] LC_FCT = 2'b00;
  localparam logic [1:0] LC_EOP = 2'b01;
  localparam logic [1:0] LC_EEP = 2'b10;
  localparam logic [1:0] LC_ESC = 2'b11;

  // Byte stored alongside marker=1 to distinguish packet terminators
  localparam logic [7:0] MK_EOP = 8'h00;
  localparam logic [7:0] MK_EEP = 8'h01;

  localparam int unsigned ENTRY_W = 9;

  // FIFO entry: marker=1 means packet terminator, otherwise a data byte
  typedef struct packed {
    logic       marker;
    logic [7:0] data;
  } rxEntry_t;

  // One-hot escape FSM
  typedef enum logic [1:0] {
    NORMAL  = 2'b01,
    ESCAPED = 2'b10
  } escState_e;

endpackage

// File: rtl/rx_ds_decode_fifo.sv
// Synchronous FIFO for decoded receive characters.
// Ports: rxClk/rxReset_n clock and async active-low reset; wrEn/wrData push
// side; rdData/rdValid/rdReady valid-ready pop side (rdData combinational from
// storage); overflow sticky flag, set when a push is dropped for lack of space.
module rx_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             rxClk,
  input  logic             rxReset_n,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             rdReady,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wrOk;

  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty = (wrPtr == rdPtr);
  assign pop   = !empty && rdReady;
  // A pop on the same edge frees a slot, so a push into a full FIFO survives
  assign wrOk  = wrEn && (!full || pop);

  assign rdValid = !empty;
  // Head forced to zero while empty so the port shows 0 after reset
  assign rdData  = empty ? '0 : mem[rdPtr[AW-1:0]];

  // Storage needs no reset; contents are only visible while not empty
  always_ff @(posedge rxClk) begin
    if (wrOk) begin
      mem[wrPtr[AW-1:0]] <= wrData;
    end
  end

  // Pointers and overflow flag
  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrOk) begin
        wrPtr <= wrPtr + (AW+1)'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + (AW+1)'(1);
      end
      if (wrEn && !wrOk) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_ds_decode.sv
// DS receive decoder: classifies assembler characters into data/markers
// (queued in a FIFO), FCT/NULL/time-code strobes, and sticky link errors.
// Ports: rxClk, rxReset_n (async active-low); q/nchar/lchar from the character
// assembler; rdData/rdValid/rdReady FIFO read port; gotFCT, gotNULL, tick
// one-cycle strobes; timeOut last time-code; gotNullSeen, escError,
// creditError sticky flags.
module rx_ds_decode
  import rx_DS_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic       rxClk,
  input  logic       rxReset_n,
  input  logic [7:0] q,
  input  logic       nchar,
  input  logic       lchar,
  output logic [8:0] rdData,
  output logic       rdValid,
  input  logic       rdReady,
  output logic       gotFCT,
  output logic       gotNULL,
  output logic       gotNullSeen,
  output logic       tick,
  output logic [7:0] timeOut,
  output logic       escError,
  output logic       creditError
);

  escState_e state;
  escState_e stateNext;
  logic      fctNext;
  logic      nullNext;
  logic      tickNext;
  logic      timeLoad;
  logic      escErrSet;
  logic      pushNext;
  rxEntry_t  pushEntryNext;
  logic      pushVld;
  rxEntry_t  pushEntry;

  // Escape FSM next state and classification
  always_comb begin
    stateNext     = state;
    fctNext       = 1'b0;
    nullNext      = 1'b0;
    tickNext      = 1'b0;
    timeLoad      = 1'b0;
    escErrSet     = 1'b0;
    pushNext      = 1'b0;
    pushEntryNext = '0;
    if (lchar) begin
      // Simultaneous nchar is an upstream fault; the L-char is still honoured
      if (nchar) begin
        escErrSet = 1'b1;
      end
      case (state)
        NORMAL: begin
          case (q[1:0])
            LC_FCT: fctNext = 1'b1;
            LC_EOP: begin
              pushNext      = 1'b1;
              pushEntryNext = '{marker: 1'b1, data: MK_EOP};
            end
            LC_EEP: begin
              pushNext      = 1'b1;
              pushEntryNext = '{marker: 1'b1, data: MK_EEP};
            end
            LC_ESC: stateNext = ESCAPED;
          endcase
        end
        ESCAPED: begin
          stateNext = NORMAL;
          if (q[1:0] == LC_FCT) begin
            nullNext = 1'b1;
          end else begin
            escErrSet = 1'b1;
          end
        end
        default: stateNext = NORMAL;
      endcase
    end else if (nchar) begin
      case (state)
        NORMAL: begin
          pushNext      = 1'b1;
          pushEntryNext = '{marker: 1'b0, data: q};
        end
        ESCAPED: begin
          tickNext  = 1'b1;
          timeLoad  = 1'b1;
          stateNext = NORMAL;
        end
        default: stateNext = NORMAL;
      endcase
    end
  end

  // State, strobes, sticky flags and the registered push request
  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) begin
      state       <= NORMAL;
      gotFCT      <= 1'b0;
      gotNULL     <= 1'b0;
      tick        <= 1'b0;
      timeOut     <= 8'h00;
      escError    <= 1'b0;
      gotNullSeen <= 1'b0;
      pushVld     <= 1'b0;
      pushEntry   <= '0;
    end else begin
      state       <= stateNext;
      gotFCT      <= fctNext;
      gotNULL     <= nullNext;
      tick        <= tickNext;
      escError    <= escError | escErrSet;
      gotNullSeen <= gotNullSeen | nullNext;
      pushVld     <= pushNext;
      pushEntry   <= pushEntryNext;
      if (timeLoad) begin
        timeOut <= q;
      end
    end
  end

  rx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uFifo (
    .rxClk     (rxClk),
    .rxReset_n (rxReset_n),
    .wrEn      (pushVld),
    .wrData    (pushEntry),
    .rdData    (rdData),
    .rdValid   (rdValid),
    .rdReady   (rdReady),
    .overflow  (creditError)
  );

endmodule

// File: tb/tb_rx_ds_decode.sv
// Self-checking bench for rx_ds_decode: table of directed vectors plus
// hand-written sequences for overflow, full push/pop and mid-escape reset.
module tb_rx_ds_decode;

  logic       rxClk;
  logic       rxReset_n;
  logic [7:0] q;
  logic       nchar;
  logic       lchar;
  logic [8:0] rdData;
  logic       rdValid;
  logic       rdReady;
  logic       gotFCT;
  logic       gotNULL;
  logic       gotNullSeen;
  logic       tick;
  logic [7:0] timeOut;
  logic       escError;
  logic       creditError;

  int nVec = 0;
  int nErr = 0;

  rx_ds_decode #(.DEPTH(8), .AW(3)) dut (
    .rxClk       (rxClk),
    .rxReset_n   (rxReset_n),
    .q           (q),
    .nchar       (nchar),
    .lchar       (lchar),
    .rdData      (rdData),
    .rdValid     (rdValid),
    .rdReady     (rdReady),
    .gotFCT      (gotFCT),
    .gotNULL     (gotNULL),
    .gotNullSeen (gotNullSeen),
    .tick        (tick),
    .timeOut     (timeOut),
    .escError    (escError),
    .creditError (creditError)
  );

  initial rxClk = 1'b0;
  always #5 rxClk = ~rxClk;

  // {rdValid, rdData, gotFCT, gotNULL, gotNullSeen, tick, timeOut, escError, creditError}
  logic [23:0] obs;
  assign obs = {rdValid, rdData, gotFCT, gotNULL, gotNullSeen, tick, timeOut, escError, creditError};

  typedef struct {
    logic        n;
    logic        l;
    logic [7:0]  qv;
    logic        rdy;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [23:0] outs(input logic v, input logic [8:0] d, input logic f,
                                       input logic nl, input logic s, input logic t,
                                       input logic [7:0] tm, input logic e, input logic c);
    return {v, d, f, nl, s, t, tm, e, c};
  endfunction

  function automatic vec_t mk(input logic n, input logic l, input logic [7:0] qv,
                              input logic rdy, input logic [23:0] exp);
    vec_t r;
    r.n = n; r.l = l; r.qv = qv; r.rdy = rdy; r.exp = exp;
    return r;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rxClk);
    #1;
  endtask

  task automatic idle();
    nchar = 1'b0;
    lchar = 1'b0;
    q     = 8'h00;
  endtask

  task automatic doReset();
    idle();
    rdReady   = 1'b0;
    rxReset_n = 1'b0;
    step();
    step();
    rxReset_n = 1'b1;
  endtask

  task automatic sendN(input logic [7:0] v);
    nchar = 1'b1;
    lchar = 1'b0;
    q     = v;
    step();
    idle();
  endtask

  initial begin
    idle();
    rdReady   = 1'b0;
    rxReset_n = 1'b0;
    #12;
    check("reset_state", obs, 24'h0);
    step();
    rxReset_n = 1'b1;

    // Tests 1-3 plus plain FCT, rdReady held high throughout
    vecs[0]  = mk(0, 1, 8'h03, 1, outs(0, 9'h000, 0, 0, 0, 0, 8'h00, 0, 0));
    vecs[1]  = mk(0, 1, 8'h00, 1, outs(0, 9'h000, 0, 1, 1, 0, 8'h00, 0, 0));
    vecs[2]  = mk(0, 0, 8'h00, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[3]  = mk(1, 0, 8'hA5, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[4]  = mk(1, 0, 8'h3C, 1, outs(1, 9'h0A5, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[5]  = mk(0, 1, 8'h01, 1, outs(1, 9'h03C, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[6]  = mk(0, 0, 8'h00, 1, outs(1, 9'h100, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[7]  = mk(0, 0, 8'h00, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[8]  = mk(0, 1, 8'h03, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs[9]  = mk(1, 0, 8'h2B, 1, outs(0, 9'h000, 0, 0, 1, 1, 8'h2B, 0, 0));
    vecs[10] = mk(0, 0, 8'h00, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h2B, 0, 0));
    vecs[11] = mk(0, 1, 8'h03, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h2B, 0, 0));
    vecs[12] = mk(0, 1, 8'h02, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h2B, 1, 0));
    vecs[13] = mk(0, 0, 8'h00, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h2B, 1, 0));
    vecs[14] = mk(0, 1, 8'h00, 1, outs(0, 9'h000, 1, 0, 1, 0, 8'h2B, 1, 0));
    vecs[15] = mk(0, 0, 8'h00, 1, outs(0, 9'h000, 0, 0, 1, 0, 8'h2B, 1, 0));

    for (int i = 0; i < 16; i++) begin
      nchar   = vecs[i].n;
      lchar   = vecs[i].l;
      q       = vecs[i].qv;
      rdReady = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end
    idle();

    // Overflow: ninth push into a full 8-entry FIFO is dropped
    doReset();
    for (int i = 0; i < 8; i++) sendN(8'(8'h10 + i));
    step();
    step();
    check("full_no_credit_err", {22'b0, rdValid, creditError}, 24'h2);
    sendN(8'h18);
    step();
    step();
    check("credit_err_set", {23'b0, creditError}, 24'h1);
    rdReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 24'(rdData), 24'(9'(8'h10 + i)));
      step();
    end
    check("drain_empty", {22'b0, rdValid, creditError}, 24'h1);

    // Push and pop on the same edge while full
    doReset();
    for (int i = 0; i < 8; i++) sendN(8'(8'h20 + i));
    step();
    step();
    sendN(8'h77);
    rdReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("fullpp%0d", i), 24'(rdData), (i == 8) ? 24'h077 : 24'(9'(8'h20 + i)));
      step();
    end
    check("fullpp_end", {22'b0, rdValid, creditError}, 24'h0);

    // Reset while escaped with entries queued
    doReset();
    sendN(8'h31);
    sendN(8'h32);
    sendN(8'h33);
    lchar = 1'b1;
    q     = 8'h03;
    step();
    idle();
    step();
    check("pre_reset_q", {14'b0, rdValid, rdData}, {14'b0, 1'b1, 9'h031});
    #2;
    rxReset_n = 1'b0;
    #1;
    check("async_reset", obs, 24'h0);
    step();
    rxReset_n = 1'b1;
    sendN(8'h11);
    step();
    check("post_reset_data", obs, outs(1, 9'h011, 0, 0, 0, 0, 8'h00, 0, 0));

    // Both strobes high: L-char wins and escError is raised
    nchar = 1'b1;
    lchar = 1'b1;
    q     = 8'h00;
    step();
    idle();
    check("both_strobes", obs, outs(1, 9'h011, 1, 0, 0, 0, 8'h00, 1, 0));
    step();
    step();
    check("both_strobes_after", obs, outs(1, 9'h011, 0, 0, 0, 0, 8'h00, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
